// File: rtl/as_arb_pkg.sv
// Shared encodings for the round-robin add/sub arbiter: FSM states and opcodes.
package as_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/as_addsub.sv
// N-bit adder-subtractor: S = A + (Op ? ~B : B) + Op, with carry-out of the MSB.
module as_addsub
  import as_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Op,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  assign b_eff       = (Op == OP_SUB) ? ~B : B;
  assign sum         = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, Op};
  assign {Cout, S}   = sum;

endmodule

// File: rtl/as_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module as_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   id,
  output logic [NREQ-1:0] onehot
);

  logic [IW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    id     = '0;
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any) begin
        idx = (int'(ptr) + k >= NREQ) ? IW'(int'(ptr) + k - NREQ) : IW'(int'(ptr) + k);
        if (req[idx]) begin
          any         = 1'b1;
          id          = idx;
          onehot[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/as_arbiter.sv
// Round-robin arbiter sharing one adder-subtractor between NREQ requesters.
// Optional AS_ARB_OVF_EN adds a registered signed-overflow result (res_ovf).
module as_arbiter
  import as_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  input  logic [NREQ-1:0]   op_in,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IW-1:0]     res_id,
  output logic [N-1:0]      res_s,
  output logic              res_cout
`ifdef AS_ARB_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  state_t          state_q, state_d;
  logic            take, capture;
  logic [IW-1:0]   ptr_q;
  logic            pick_any;
  logic [IW-1:0]   pick_id;
  logic [NREQ-1:0] pick_onehot;
  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];
  logic [N-1:0]    a_r, b_r;
  logic            op_r;
  logic [IW-1:0]   id_r;
  logic [N-1:0]    s_dp;
  logic            cout_dp;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = a_in[i*N +: N];
    assign b_arr[i] = b_in[i*N +: N];
  end

  as_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .id     (pick_id),
    .onehot (pick_onehot)
  );

  as_addsub #(.N(N)) u_addsub (
    .A    (a_r),
    .B    (b_r),
    .Op   (op_r),
    .S    (s_dp),
    .Cout (cout_dp)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (pick_any) begin
        take    = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_s     <= '0;
      res_cout  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= take ? pick_onehot : '0;
      if (take) ptr_q <= (pick_id == IW'(NREQ - 1)) ? '0 : pick_id + IW'(1);
      if (capture) begin
        res_valid <= 1'b1;
        res_id    <= id_r;
        res_s     <= s_dp;
        res_cout  <= cout_dp;
      end else if (state_q == DONE && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Winner's operands are sampled once and stay put for the whole EXEC cycle.
  always_ff @(posedge clk) begin
    if (take) begin
      a_r  <= a_arr[pick_id];
      b_r  <= b_arr[pick_id];
      op_r <= op_in[pick_id];
      id_r <= pick_id;
    end
  end

`ifdef AS_ARB_OVF_EN
  logic [N-1:0] b_eff;
  logic         ovf_dp;

  assign b_eff  = (op_r == OP_SUB) ? ~b_r : b_r;
  assign ovf_dp = (a_r[N-1] == b_eff[N-1]) && (s_dp[N-1] != a_r[N-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       res_ovf <= 1'b0;
    else if (capture) res_ovf <= ovf_dp;
  end
`endif

endmodule

// File: tb/tb_as_arbiter.sv
// Self-checking bench for as_arbiter: transaction-level model plus directed vectors.
module tb_as_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_in, b_in;
  logic [NREQ-1:0]   op_in;
  logic              res_ready;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic [IW-1:0]     res_id;
  logic [N-1:0]      res_s;
  logic              res_cout;
`ifdef AS_ARB_OVF_EN
  logic              res_ovf;
`endif

  always #5 clk = ~clk;

  as_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_s     (res_s),
    .res_cout  (res_cout)
`ifdef AS_ARB_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request yields gnt next cycle, a result one
  // cycle later, held until consumed; only a free arbiter accepts new requests.
  logic [NREQ-1:0] m_gnt;
  bit   m_pend, m_valid, m_fresh, p_op;
  int   m_ptr, m_id, m_s, m_cout, p_a, p_b, p_id, w, sa, sb, r;
`ifdef AS_ARB_OVF_EN
  int   m_ovf;
`endif

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_gnt = '0; m_pend = 0; m_valid = 0; m_fresh = 1; m_ptr = 0;
      m_id = 0; m_s = 0; m_cout = 0;
`ifdef AS_ARB_OVF_EN
      m_ovf = 0;
`endif
    end else if (m_pend) begin
      m_gnt = '0; m_pend = 0; m_valid = 1; m_fresh = 0; m_id = p_id;
      if (p_op) begin
        m_s = (p_a - p_b + 16) % 16; m_cout = (p_a >= p_b) ? 1 : 0;
      end else begin
        m_s = (p_a + p_b) % 16; m_cout = (p_a + p_b >= 16) ? 1 : 0;
      end
      sa = (p_a >= 8) ? p_a - 16 : p_a;
      sb = (p_b >= 8) ? p_b - 16 : p_b;
      r  = p_op ? sa - sb : sa + sb;
`ifdef AS_ARB_OVF_EN
      m_ovf = (r > 7 || r < -8) ? 1 : 0;
`endif
    end else if (m_valid) begin
      m_gnt = '0;
      if (res_ready) m_valid = 0;
    end else begin
      m_gnt = '0;
      if (req != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_gnt[w] = 1'b1;
        p_a = int'(a_in[w*N +: N]); p_b = int'(b_in[w*N +: N]);
        p_op = op_in[w]; p_id = w;
        m_ptr = (w + 1) % NREQ;
        m_pend = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("gnt", gnt, m_gnt);
    check("res_valid", res_valid, m_valid);
    if (m_valid || m_fresh) begin
      check("res_id", res_id, m_id);
      check("res_s", res_s, m_s);
      check("res_cout", res_cout, m_cout);
`ifdef AS_ARB_OVF_EN
      check("res_ovf", res_ovf, m_ovf);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input bit op);
    a_in[i*N +: N] = N'(a);
    b_in[i*N +: N] = N'(b);
    op_in[i]       = op;
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g);
    g = '0;
    for (int c = 0; c < 20 && g == '0; c++) begin
      tick();
      g = gnt;
    end
    check("gnt_seen", (g != '0), 1);
  endtask

  task automatic run_op(input int i, input int a, input int b, input bit op,
                        input int es, input int ec, input string tag);
    logic [NREQ-1:0] g;
    req = '0;
    set_op(i, a, b, op);
    req[i] = 1'b1;
    wait_gnt(g);
    check({tag, "_gnt"}, g, 32'(1) << i);
    req[i] = 1'b0;
    tick();
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_id"}, res_id, i);
    check({tag, "_s"}, res_s, es);
    check({tag, "_cout"}, res_cout, ec);
    tick();
    check({tag, "_valid_drop"}, res_valid, 0);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    int gid [8];
    int gcyc [8];
    int ng;

    req = '0; a_in = '0; b_in = '0; op_in = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_valid", res_valid, 0);
    check("rst_id", res_id, 0);
    check("rst_s", res_s, 0);
    check("rst_cout", res_cout, 0);
    rst_n = 1'b1;
    tick();

    run_op(0, 2, 1, 1'b0, 3, 0, "add_2_1");
    run_op(1, 7, 3, 1'b1, 4, 1, "sub_7_3");
    run_op(1, 1, 3, 1'b1, 14, 0, "sub_1_3");
    run_op(2, 7, 2, 1'b0, 9, 0, "add_7_2");
`ifdef AS_ARB_OVF_EN
    check("ovf_7_2", res_ovf, 1);
`endif
    run_op(3, 12, 4, 1'b1, 8, 1, "sub_12_4");
`ifdef AS_ARB_OVF_EN
    check("ovf_12_4", res_ovf, 0);
`endif

    // All four requesting continuously: rotation and issue rate
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 1, 1'b0);
    req = '1;
    rst_n = 1'b1;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (gnt != '0 && ng < 8) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gid[ng] = i;
        gcyc[ng] = c;
        ng++;
      end
    end
    req = '0;
    check("rr_count_ge5", (ng >= 5), 1);
    if (ng >= 5) begin
      check("rr_order0", gid[0], 0);
      check("rr_order1", gid[1], 1);
      check("rr_order2", gid[2], 2);
      check("rr_order3", gid[3], 3);
      check("rr_order4", gid[4], 0);
      for (int j = 0; j < 4; j++) check("rr_spacing", gcyc[j+1] - gcyc[j], 3);
    end
    repeat (4) tick();

    // Backpressure: result held, pending request not granted
    rst_n = 1'b0;
    tick();
    res_ready = 1'b0;
    rst_n = 1'b1;
    set_op(0, 5, 6, 1'b0);
    req = 4'b0001;
    wait_gnt(g);
    check("bp_gnt0", g, 4'b0001);
    set_op(2, 3, 3, 1'b1);
    req = 4'b0100;
    tick();
    check("bp_valid", res_valid, 1);
    check("bp_s", res_s, 11);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_s", res_s, 11);
      check("bp_hold_id", res_id, 0);
      check("bp_no_gnt", gnt, 0);
    end
    res_ready = 1'b1;
    wait_gnt(g);
    check("bp_gnt2", g, 4'b0100);
    req = '0;
    tick();
    check("bp_res2_id", res_id, 2);
    check("bp_res2_s", res_s, 0);
    check("bp_res2_cout", res_cout, 1);
    repeat (2) tick();

    // Reset while EXEC: operation discarded, ptr back to 0
    set_op(0, 1, 1, 1'b0);
    req = 4'b0001;
    wait_gnt(g);
    check("mid_gnt", g, 4'b0001);
    req = '0;
    #2 rst_n = 1'b0;
    tick();
    check("mid_valid", res_valid, 0);
    check("mid_gnt_clr", gnt, 0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid_no_valid", res_valid, 0);
    end
    for (int i = 0; i < NREQ; i++) set_op(i, 2, 2, 1'b0);
    req = '1;
    wait_gnt(g);
    check("mid_ptr_reset", g, 4'b0001);
    req = '0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
